// File: rtl/tri_fu_mul_bthseq_if.sv
// rtl/tri_fu_mul_bthseq_if.sv - operand/product handshake bundle for the iterative Booth multiplier
interface tri_fu_mul_bthseq_if #(
    parameter int WIDTH = 16
);
    logic               in_valid;
    logic               in_ready;
    logic               in_signed;
    logic [0:WIDTH-1]   in_a;
    logic [0:WIDTH-1]   in_b;
    logic               out_valid;
    logic               out_ready;
    logic [0:2*WIDTH-1] out_p;

    modport master (
        output in_valid, in_signed, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_signed, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/tri_fu_mul_bthseq.sv
// rtl/tri_fu_mul_bthseq.sv - iterative radix-4 Booth multiplier, DIGITS digits retired per cycle
module tri_fu_mul_bthseq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    tri_fu_mul_bthseq_if.slave bus
);
    localparam int ND  = WIDTH / 2 + 1;
    localparam int AW  = 2 * WIDTH + 4;
    localparam int BW  = WIDTH + 3;
    localparam int BSW = 2 * DIGITS + 1;
    localparam int CW  = $clog2(ND + DIGITS + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH+1:0] a_q, a_d;
    logic [BW-1:0]    b_q, b_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] op_a, op_b;
    logic             ext_a, ext_b, accept, last_step;
    logic [CW:0]      shamt;
    logic [BSW-1:0]   b_sh;
    logic [AW-1:0]    m_sh, mag, pp_sum;
    logic [2:0]       trip;

    assign op_a  = bus.in_a;
    assign op_b  = bus.in_b;
    assign ext_a = bus.in_signed & op_a[WIDTH-1];
    assign ext_b = bus.in_signed & op_b[WIDTH-1];

    assign bus.in_ready = ~rst & ~flush &
                          ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_p     = acc_q[2*WIDTH-1:0];

    // b_q carries the implied b[-1]=0 at bit 0, so digit j's triple sits at b_q[2j+2:2j].
    assign last_step = (int'(cnt_q) + DIGITS >= ND);
    assign shamt     = {cnt_q, 1'b0};
    assign b_sh      = BSW'(b_q >> shamt);
    assign m_sh      = {{(WIDTH + 2){a_q[WIDTH+1]}}, a_q} << shamt;

    always_comb begin
        pp_sum = '0;
        trip   = '0;
        mag    = '0;
        for (int d = 0; d < DIGITS; d++) begin
            trip = b_sh[2*d +: 3];
            mag  = '0;
            if (trip[1] ^ trip[0])
                mag = m_sh << (2 * d);
            else if ((trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]))
                mag = m_sh << (2 * d + 1);
            // Digits past the top of the extended multiplier add nothing.
            if (int'(cnt_q) + d < ND)
                pp_sum = trip[2] ? (pp_sum - mag) : (pp_sum + mag);
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: begin
                acc_d = acc_q + pp_sum;
                cnt_d = cnt_q + CW'(DIGITS);
                if (last_step) state_d = DONE;
            end
            DONE: if (bus.out_ready) state_d = accept ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            a_d   = {{2{ext_a}}, op_a};
            b_d   = {{2{ext_b}}, op_b, 1'b0};
            acc_d = '0;
            cnt_d = '0;
        end
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
        // Operands only move on accept, and accept is impossible while rst is high.
        a_q <= a_d;
        b_q <= b_d;
    end
endmodule
